neuron_mac: RTL and testbench
=============================

NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter numWeight, default 3: inputs per vector, which is also the weight memory depth.
REQ-002 SHALL have parameter addressWidth, default 5: weight read address width.
REQ-003 SHALL have parameter dataWidth, default 16: signed fixed-point width of inputs, weights, bias and output.
REQ-004 SHALL have parameter fracBits, default 8: number of fractional bits; default format is Q8.8.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-007 SHALL have port myinput, input, dataWidth bits: input activation.
REQ-008 SHALL have port myinputValid, input, 1 bit: qualifies myinput.
REQ-009 SHALL have port biasIn, input, dataWidth bits: bias value.
REQ-010 SHALL have port biasValid, input, 1 bit: loads biasIn into the bias register.
REQ-011 SHALL have port ren, output, 1 bit: weight memory read enable.
REQ-012 SHALL have port radd, output, addressWidth bits: weight memory read address.
REQ-013 SHALL have port weightIn, input, dataWidth bits: weight memory read data, valid 1 cycle after ren.
REQ-014 SHALL have port out, output, dataWidth bits: saturated neuron sum.
REQ-015 SHALL have port outvalid, output, 1 bit: one-cycle pulse qualifying out.

Function
REQ-016 SHALL drive ren combinationally equal to myinputValid, and SHALL drive radd from an address counter.
REQ-017 Address counter SHALL increment on each edge with myinputValid=1 and SHALL wrap from numWeight-1 to 0.
REQ-018 Stage 1 (edge E0, myinputValid=1): SHALL register myinput and a valid flag alongside the memory read.
REQ-019 Stage 2 (E1): SHALL register the product: full 2*dataWidth signed product of input and weightIn, arithmetic-shifted right by fracBits, saturated to dataWidth.
REQ-020 Stage 3 (E2): SHALL update the accumulator: load the product if it is the first of a vector, otherwise saturating-add it.
REQ-021 A product counter SHALL count stage-3 updates modulo numWeight to mark the first and last product of each vector.
REQ-022 Stage 4 (E3, after the last product): SHALL load out with the saturating sum of accumulator and bias, with outvalid=1 for exactly one cycle.
REQ-023 Latency from the edge sampling the last myinputValid to outvalid high SHALL be 3 clocks.
REQ-024 Saturation SHALL clamp to 0x7FFF on positive overflow and 0x8000 on negative overflow, for dataWidth=16.
REQ-025 Back-to-back vectors with no idle cycles SHALL be supported: the first product of the next vector loads the accumulator in the same cycle that stage 4 reads the previous sum.
REQ-026 Gaps (myinputValid=0) SHALL stall nothing but insert bubbles; partial sums SHALL be held indefinitely.
REQ-027 A bias update via biasValid SHALL take effect from the next edge; a bias update coinciding with stage 4 SHALL NOT affect that output (the old bias is used).
REQ-028 out SHALL hold its value between outvalid pulses.

Reset
REQ-029 rst=1 SHALL asynchronously clear out, outvalid, accumulator, bias, address counter, product counter and all pipeline valid flags to 0.
REQ-030 Reset mid-vector SHALL discard the partial sum and SHALL NOT produce an outvalid pulse for that vector.
REQ-031 The first vector after reset release SHALL start at address 0.

Structure
REQ-032 Default dataWidth/fracBits and the saturation limits SHALL live in the shared include file.
REQ-033 Saturating signed add SHALL be a sub-module sat_add, instantiated for accumulation and for the bias add.
REQ-034 Implementation SHALL be 120-400 lines of RTL with no vendor primitives.

Verification (dataWidth=16, fracBits=8, numWeight=3, weights 0x0100, 0x0200, 0xFF80)
REQ-035 Basic: bias 0x0040, inputs 0x0100, 0x0080, 0x0200 on consecutive cycles -> out=0x0140 with a single outvalid pulse 3 clocks after the third input.
REQ-036 Saturation: weights 0x7F00 x3, inputs 0x7F00 x3, bias 0 -> out=0x7FFF; all weights negated -> out=0x8000.
REQ-037 Back-to-back: two vectors as in REQ-035 with no gap -> two outvalid pulses 3 clocks apart, both out=0x0140, radd sequence 0,1,2,0,1,2.
REQ-038 Reset mid-vector: rst pulse after 2 inputs, then a full vector -> no pulse for the aborted vector, correct out=0x0140, radd restarts at 0.
REQ-039 Gapped input plus bias change: inputs separated by 2-cycle gaps, biasValid with 0x0000 asserted during the gaps -> out=0x0100.

Source files
------------

// File: rtl/neuron_mac_pkg.sv
// Shared defaults for the neuron MAC: fixed-point format, memory depth and
// the saturation limits of the default Q8.8 data path.
package neuron_mac_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;
  localparam int NUM_WEIGHT = 3;
  localparam int ADDR_WIDTH = 5;

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/neuron_mac_sat_add.sv
// Combinational signed adder that clamps to the most positive / most negative
// representable value instead of wrapping.
module sat_add #(
  parameter int width = 16
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] sum
);

  localparam logic [width-1:0] max_val = {1'b0, {(width-1){1'b1}}};
  localparam logic [width-1:0] min_val = {1'b1, {(width-1){1'b0}}};

  logic [width:0] sum_full;

  assign sum_full = {a[width-1], a} + {b[width-1], b};

  // NOTE: every path of an always_comb assigns sum, so no latch can be inferred.
  always_comb begin
    sum = sum_full[width-1:0];
    // Overflow shows up as the extra sign bit disagreeing with the result sign.
    if (sum_full[width] != sum_full[width-1])
      sum = sum_full[width] ? min_val : max_val;
  end

endmodule

// File: rtl/neuron_mac.sv
// Four-stage fixed-point neuron: fetch weight, multiply, accumulate, add bias.
// Each vector of numWeight inputs yields one saturated sum with a valid pulse.
module neuron_mac
  import neuron_mac_pkg::*;
#(
  parameter int numWeight    = NUM_WEIGHT,
  parameter int addressWidth = ADDR_WIDTH,
  parameter int dataWidth    = DATA_WIDTH,
  parameter int fracBits     = FRAC_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [dataWidth-1:0]    myinput,
  input  logic                    myinputValid,
  input  logic [dataWidth-1:0]    biasIn,
  input  logic                    biasValid,
  output logic                    ren,
  output logic [addressWidth-1:0] radd,
  input  logic [dataWidth-1:0]    weightIn,
  output logic [dataWidth-1:0]    out,
  output logic                    outvalid
);

  localparam logic [dataWidth-1:0]    max_val  = {1'b0, {(dataWidth-1){1'b1}}};
  localparam logic [dataWidth-1:0]    min_val  = {1'b1, {(dataWidth-1){1'b0}}};
  localparam logic [addressWidth-1:0] last_idx = addressWidth'(numWeight - 1);

  logic [addressWidth-1:0] addr_cnt;
  logic [addressWidth-1:0] prod_cnt;
  logic [dataWidth-1:0]    in_r;
  logic [dataWidth-1:0]    prod_r;
  logic [dataWidth-1:0]    prod_sat;
  logic [dataWidth-1:0]    acc;
  logic [dataWidth-1:0]    acc_sum;
  logic [dataWidth-1:0]    bias_r;
  logic [dataWidth-1:0]    biased;
  logic                    v1, v2, v3;

  logic signed [2*dataWidth-1:0] prod_full;
  logic signed [2*dataWidth-1:0] prod_shift;
  logic        [dataWidth:0]     prod_upper;

  assign ren  = myinputValid;
  assign radd = addr_cnt;

  assign prod_full  = $signed(in_r) * $signed(weightIn);
  assign prod_shift = prod_full >>> fracBits;
  assign prod_upper = prod_shift[2*dataWidth-1:dataWidth-1];

  // The shifted product fits only if all bits above the result are sign copies.
  always_comb begin
    prod_sat = prod_shift[dataWidth-1:0];
    if (!((&prod_upper) || !(|prod_upper)))
      prod_sat = prod_upper[dataWidth] ? min_val : max_val;
  end

  sat_add #(.width(dataWidth)) u_acc_add (
    .a   (acc),
    .b   (prod_r),
    .sum (acc_sum)
  );

  sat_add #(.width(dataWidth)) u_bias_add (
    .a   (acc),
    .b   (bias_r),
    .sum (biased)
  );

  // NOTE: state uses non-blocking assignments so every stage samples the
  // pre-edge values of the others; this is what lets stage 4 read the old
  // sum and old bias while stage 3 reloads the accumulator on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt <= '0;
      prod_cnt <= '0;
      in_r     <= '0;
      prod_r   <= '0;
      acc      <= '0;
      bias_r   <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      out      <= '0;
      outvalid <= 1'b0;
    end else begin
      if (biasValid)
        bias_r <= biasIn;

      v1 <= myinputValid;
      if (myinputValid) begin
        in_r     <= myinput;
        addr_cnt <= (addr_cnt == last_idx) ? '0 : addr_cnt + 1'b1;
      end

      v2 <= v1;
      if (v1)
        prod_r <= prod_sat;

      v3 <= v2 && (prod_cnt == last_idx);
      if (v2) begin
        acc      <= (prod_cnt == '0) ? prod_r : acc_sum;
        prod_cnt <= (prod_cnt == last_idx) ? '0 : prod_cnt + 1'b1;
      end

      outvalid <= v3;
      if (v3)
        out <= biased;
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: stimulus queues expected sums with their due
// cycle, an independent monitor checks every outvalid pulse against the queue.
module tb_neuron_mac;
  import neuron_mac_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] myinput = '0;
  logic        myinputValid = 1'b0;
  logic [15:0] biasIn = '0;
  logic        biasValid = 1'b0;
  logic        ren;
  logic [4:0]  radd;
  logic [15:0] weightIn = '0;
  logic [15:0] out;
  logic        outvalid;

  neuron_mac dut (
    .clk          (clk),
    .rst          (rst),
    .myinput      (myinput),
    .myinputValid (myinputValid),
    .biasIn       (biasIn),
    .biasValid    (biasValid),
    .ren          (ren),
    .radd         (radd),
    .weightIn     (weightIn),
    .out          (out),
    .outvalid     (outvalid)
  );

  always #5 clk = ~clk;

  logic [15:0] wmem [4];
  always @(posedge clk) if (ren) weightIn <= (radd < 5'd3) ? wmem[radd[1:0]] : 16'hxxxx;

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          exp_addr = 0;
  logic [15:0] last_out = '0;
  logic        hold_pending = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one input; when last is set the sum is due 4 negedges later
  // (sampling edge E0, then E1, E2, and outvalid rises on E3).
  task automatic send(input logic [15:0] x, input logic last, input logic [15:0] expv);
    @(negedge clk);
    myinput      = x;
    myinputValid = 1'b1;
    biasValid    = 1'b0;
    #1;
    check("ren", ren, 1);
    check("radd", radd, exp_addr);
    exp_addr = (exp_addr + 1) % 3;
    if (last) q.push_back('{expv, cyc + 4});
  endtask

  task automatic step(input logic bias_en, input logic [15:0] bias_val);
    @(negedge clk);
    myinputValid = 1'b0;
    biasValid    = bias_en;
    biasIn       = bias_val;
  endtask

  task automatic drain();
    repeat (8) step(1'b0, 16'h0000);
  endtask

  task automatic set_weights(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    wmem[0] = w0;
    wmem[1] = w1;
    wmem[2] = w2;
    wmem[3] = 16'h0000;
  endtask

  always @(negedge clk) begin
    if (!rst && outvalid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_outvalid out=%h expected=no pulse (t=%0t)", out, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out", out, e.val);
        check("latency", cyc, e.due);
      end
      last_out     = out;
      hold_pending = 1'b1;
    end else if (hold_pending) begin
      check("out_hold", out, last_out);
      hold_pending = 1'b0;
    end
  end

  initial begin
    set_weights(16'h0100, 16'h0200, 16'hFF80);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out", out, 0);
    check("rst_outvalid", outvalid, 0);
    check("rst_radd", radd, 0);
    check("rst_ren", ren, 0);
    rst = 1'b0;

    // Basic vector; a bias write lands on the stage-4 edge and must not count
    step(1'b1, 16'h0040);
    send(16'h0100, 1'b0, 16'h0);
    send(16'h0080, 1'b0, 16'h0);
    send(16'h0200, 1'b1, 16'h0140);
    step(1'b0, 16'h0);
    step(1'b0, 16'h0);
    step(1'b1, 16'h0000);
    drain();

    // Back-to-back vectors
    step(1'b1, 16'h0040);
    send(16'h0100, 1'b0, 16'h0);
    send(16'h0080, 1'b0, 16'h0);
    send(16'h0200, 1'b1, 16'h0140);
    send(16'h0100, 1'b0, 16'h0);
    send(16'h0080, 1'b0, 16'h0);
    send(16'h0200, 1'b1, 16'h0140);
    drain();

    // Reset mid-vector, then a full vector from address 0
    send(16'h0100, 1'b0, 16'h0);
    send(16'h0080, 1'b0, 16'h0);
    @(negedge clk);
    myinputValid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out", out, 0);
    check("midrst_radd", radd, 0);
    exp_addr = 0;
    @(negedge clk);
    rst = 1'b0;
    drain();
    step(1'b1, 16'h0040);
    send(16'h0100, 1'b0, 16'h0);
    send(16'h0080, 1'b0, 16'h0);
    send(16'h0200, 1'b1, 16'h0140);
    drain();

    // Positive and negative saturation
    set_weights(16'h7F00, 16'h7F00, 16'h7F00);
    step(1'b1, 16'h0000);
    send(16'h7F00, 1'b0, 16'h0);
    send(16'h7F00, 1'b0, 16'h0);
    send(16'h7F00, 1'b1, SAT_MAX);
    drain();
    set_weights(16'h8100, 16'h8100, 16'h8100);
    send(16'h7F00, 1'b0, 16'h0);
    send(16'h7F00, 1'b0, 16'h0);
    send(16'h7F00, 1'b1, SAT_MIN);
    drain();

    // Gapped inputs with a bias change inside the gaps
    set_weights(16'h0100, 16'h0200, 16'hFF80);
    step(1'b1, 16'h0040);
    send(16'h0100, 1'b0, 16'h0);
    step(1'b1, 16'h0000);
    step(1'b0, 16'h0);
    send(16'h0080, 1'b0, 16'h0);
    step(1'b0, 16'h0);
    step(1'b1, 16'h0000);
    send(16'h0200, 1'b1, 16'h0100);
    drain();

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    check("queue_empty", q.size(), 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
